// File: rtl/fnd_pkg.sv
// rtl/fnd_pkg.sv - shared FND font table, widths and scan decoder types
package fnd_pkg;

  localparam int VALUE_W = 14;
  localparam int DIGIT_N = 4;
  localparam int BCD_W   = 4;

  // Active-low g..a segments with dp forced high
  localparam logic [7:0] FONT_0     = 8'hC0;
  localparam logic [7:0] FONT_1     = 8'hF9;
  localparam logic [7:0] FONT_2     = 8'hA4;
  localparam logic [7:0] FONT_3     = 8'hB0;
  localparam logic [7:0] FONT_4     = 8'h99;
  localparam logic [7:0] FONT_5     = 8'h92;
  localparam logic [7:0] FONT_6     = 8'h82;
  localparam logic [7:0] FONT_7     = 8'hF8;
  localparam logic [7:0] FONT_8     = 8'h80;
  localparam logic [7:0] FONT_9     = 8'h90;
  localparam logic [7:0] FONT_BLANK = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_CAPTURE,
    S_HOLD,
    S_COMMIT
  } scan_state_t;

  typedef struct packed {
    logic       single;
    logic [1:0] slot;
  } anode_t;

  function automatic anode_t decode_anode(input logic [DIGIT_N-1:0] d);
    anode_t a;
    a.single = 1'b1;
    a.slot   = 2'd0;
    case (d)
      4'b1110: a.slot = 2'd0;
      4'b1101: a.slot = 2'd1;
      4'b1011: a.slot = 2'd2;
      4'b0111: a.slot = 2'd3;
      default: a.single = 1'b0;
    endcase
    return a;
  endfunction

  function automatic logic [7:0] bcd_to_font(input logic [BCD_W-1:0] bcd);
    case (bcd)
      4'd0:    return FONT_0;
      4'd1:    return FONT_1;
      4'd2:    return FONT_2;
      4'd3:    return FONT_3;
      4'd4:    return FONT_4;
      4'd5:    return FONT_5;
      4'd6:    return FONT_6;
      4'd7:    return FONT_7;
      4'd8:    return FONT_8;
      4'd9:    return FONT_9;
      default: return FONT_BLANK;
    endcase
  endfunction

  function automatic logic [VALUE_W-1:0] bcd_to_value(
    input logic [BCD_W-1:0] d3,
    input logic [BCD_W-1:0] d2,
    input logic [BCD_W-1:0] d1,
    input logic [BCD_W-1:0] d0
  );
    return VALUE_W'(d3) * VALUE_W'(1000) + VALUE_W'(d2) * VALUE_W'(100)
         + VALUE_W'(d1) * VALUE_W'(10) + VALUE_W'(d0);
  endfunction

endpackage

// File: rtl/fnd_font_to_bcd.sv
// rtl/fnd_font_to_bcd.sv - combinational 7-segment font to BCD digit decoder
module fnd_font_to_bcd
  import fnd_pkg::*;
(
  input  logic [7:0]       font,
  output logic [BCD_W-1:0] bcd,
  output logic             valid
);

  // Caller forces dp high, so the full byte is compared against the table
  always_comb begin
    bcd   = '0;
    valid = 1'b1;
    case (font)
      FONT_0:  bcd = 4'd0;
      FONT_1:  bcd = 4'd1;
      FONT_2:  bcd = 4'd2;
      FONT_3:  bcd = 4'd3;
      FONT_4:  bcd = 4'd4;
      FONT_5:  bcd = 4'd5;
      FONT_6:  bcd = 4'd6;
      FONT_7:  bcd = 4'd7;
      FONT_8:  bcd = 4'd8;
      FONT_9:  bcd = 4'd9;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/fnd_scan_decoder.sv
// rtl/fnd_scan_decoder.sv - recovers the displayed 4-digit value from FND scan lines
module fnd_scan_decoder
  import fnd_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int BLANK_CYCLES  = 200000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [DIGIT_N-1:0] i_FND_Digit,
  input  logic [7:0]         i_FND_Font,
  output logic [VALUE_W-1:0] o_value,
  output logic               o_valid,
  output logic               o_err,
  output logic               o_blank
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int BW = $clog2(BLANK_CYCLES + 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(STABLE_CYCLES);
  localparam logic [BW-1:0] BLANK_MAX  = BW'(BLANK_CYCLES);
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);

  logic [DIGIT_N-1:0] dig_q, dig_p, cap_dig;
  logic [7:0]         font_q, font_p, cap_font;
  logic [SW-1:0]      stab_cnt;
  logic [BW-1:0]      blank_cnt;
  logic [DIGIT_N-1:0] seen, seen_cap;
  logic [BCD_W-1:0]   digits [DIGIT_N];
  logic [BCD_W-1:0]   cap_bcd;
  logic               cap_ok, changed, all_high, blank_hit;
  anode_t             cur, cap;
  scan_state_t        state, state_n;

  fnd_font_to_bcd u_font_to_bcd (
    .font  (cap_font),
    .bcd   (cap_bcd),
    .valid (cap_ok)
  );

  assign cur       = decode_anode(dig_q);
  assign cap       = decode_anode(cap_dig);
  assign changed   = (dig_q != dig_p) || (font_q != font_p);
  assign all_high  = &dig_q;
  assign blank_hit = all_high && (blank_cnt == BLANK_LAST);
  assign seen_cap  = seen | (DIGIT_N'(1) << cap.slot);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:    if (cur.single) state_n = S_SETTLE;
      S_SETTLE: begin
        if (!cur.single)                              state_n = S_IDLE;
        else if (stab_cnt == STABLE_MAX && !changed)  state_n = S_CAPTURE;
      end
      S_CAPTURE: state_n = (cap_ok && (&seen_cap)) ? S_COMMIT : S_HOLD;
      S_HOLD:    if (dig_q != cap_dig) state_n = cur.single ? S_SETTLE : S_IDLE;
      S_COMMIT:  state_n = S_HOLD;
      default:   state_n = S_IDLE;
    endcase
  end

  // Input stage, glitch filter and blank detection
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      dig_q     <= '1;
      dig_p     <= '1;
      font_q    <= FONT_BLANK;
      font_p    <= FONT_BLANK;
      stab_cnt  <= '0;
      blank_cnt <= '0;
      o_blank   <= 1'b0;
    end else begin
      dig_q  <= i_FND_Digit;
      font_q <= i_FND_Font | 8'h80;
      dig_p  <= dig_q;
      font_p <= font_q;
      if (!cur.single || changed)     stab_cnt <= '0;
      else if (stab_cnt != STABLE_MAX) stab_cnt <= stab_cnt + 1'b1;
      if (!all_high)                  blank_cnt <= '0;
      else if (blank_cnt != BLANK_MAX) blank_cnt <= blank_cnt + 1'b1;
      o_blank <= all_high && (o_blank || blank_hit);
    end
  end

  // Capture, frame assembly and output registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cap_dig  <= '1;
      cap_font <= FONT_BLANK;
      seen     <= '0;
      for (int i = 0; i < DIGIT_N; i++) digits[i] <= '0;
      o_value  <= '0;
      o_valid  <= 1'b0;
      o_err    <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      o_err   <= 1'b0;
      if (state == S_SETTLE && state_n == S_CAPTURE) begin
        cap_dig  <= dig_q;
        cap_font <= font_q;
      end
      case (state)
        S_CAPTURE: begin
          if (cap_ok) begin
            digits[cap.slot] <= cap_bcd;
            seen             <= seen_cap;
          end else begin
            seen  <= '0;
            o_err <= 1'b1;
          end
        end
        S_COMMIT: begin
          o_value <= bcd_to_value(digits[3], digits[2], digits[1], digits[0]);
          o_valid <= 1'b1;
          seen    <= '0;
        end
        default: ;
      endcase
      if (blank_hit) seen <= '0;
    end
  end

endmodule

// File: tb/tb_fnd_scan_decoder.sv
// tb/tb_fnd_scan_decoder.sv - randomized scoreboard bench for fnd_scan_decoder
module tb_fnd_scan_decoder;

  localparam int STABLE = 4;
  localparam int BLANK  = 64;
  localparam int P10 [4] = '{1, 10, 100, 1000};

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  dig;
  logic [7:0]  font;
  logic [13:0] value;
  logic        valid, err, blank;

  int passed = 0;
  int total  = 0;

  logic [7:0] font_tab [10];
  int m_digit [4];
  bit m_seen  [4];
  int m_last = 0;
  int exp_val_q [$];
  int exp_err_q [$];

  fnd_scan_decoder #(.STABLE_CYCLES(STABLE), .BLANK_CYCLES(BLANK)) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_FND_Digit (dig),
    .i_FND_Font  (font),
    .o_value     (value),
    .o_valid     (valid),
    .o_err       (err),
    .o_blank     (blank)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int font_index(input logic [7:0] f);
    for (int i = 0; i < 10; i++)
      if (font_tab[i] == (f | 8'h80)) return i;
    return -1;
  endfunction

  function automatic logic [7:0] font_of(input int v, input int k);
    return font_tab[(v / P10[k]) % 10];
  endfunction

  function automatic logic [7:0] bad_font();
    logic [7:0] f;
    f = 8'($urandom) | 8'h80;
    while (font_index(f) >= 0) f = 8'($urandom) | 8'h80;
    return f;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) m_seen[i] = 1'b0;
  endtask

  // One captured digit: either a frame slot fills or the frame is thrown away
  task automatic model_capture(input int k, input logic [7:0] f);
    int idx;
    idx = font_index(f);
    if (idx < 0) begin
      exp_err_q.push_back(m_last);
      model_clear();
    end else begin
      m_digit[k] = idx;
      m_seen[k]  = 1'b1;
      if (m_seen[0] && m_seen[1] && m_seen[2] && m_seen[3]) begin
        m_last = m_digit[3] * 1000 + m_digit[2] * 100 + m_digit[1] * 10 + m_digit[0];
        exp_val_q.push_back(m_last);
        model_clear();
      end
    end
  endtask

  // dp is randomised every cycle; the decoder must ignore it
  task automatic hold(input logic [3:0] d, input logic [7:0] f, input int n);
    repeat (n) begin
      dig  = d;
      font = {1'($urandom_range(0, 1)), f[6:0]};
      @(negedge clk);
    end
  endtask

  task automatic gap(input int n);
    logic [3:0] pats [4];
    pats = '{4'hF, 4'h0, 4'h5, 4'hC};
    hold(pats[$urandom_range(0, 3)], 8'hFF, n);
  endtask

  task automatic dwell(input int k, input logic [7:0] f, input int glitch,
                       input logic [7:0] gfont, input int len);
    logic [3:0] an;
    an    = 4'hF;
    an[k] = 1'b0;
    model_capture(k, f);
    if (glitch > 0) hold(an, gfont, glitch);
    hold(an, f, len);
    gap($urandom_range(1, 2));
  endtask

  task automatic scan_value(input int v, input int glitch, input int len);
    for (int k = 0; k < 4; k++) dwell(k, font_of(v, k), glitch, 8'h80, len);
  endtask

  task automatic random_frame();
    int v, t;
    int ord [4];
    logic [7:0] f;
    v   = $urandom_range(0, 9999);
    ord = '{0, 1, 2, 3};
    for (int i = 3; i > 0; i--) begin
      int j;
      j = $urandom_range(0, i);
      t = ord[i]; ord[i] = ord[j]; ord[j] = t;
    end
    for (int i = 0; i < 4; i++) begin
      f = ($urandom_range(0, 9) == 0) ? bad_font() : font_of(v, ord[i]);
      dwell(ord[i], f, $urandom_range(0, 2), 8'($urandom), $urandom_range(12, 20));
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (valid) begin
        if (exp_val_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_valid: got o_value=%0d expected no pulse", value);
        end else check("o_value", value, exp_val_q.pop_front());
      end
      if (err) begin
        if (exp_err_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_err: got o_err=1 expected 0 (o_value=%0d)", value);
        end else check("o_value_at_err", value, exp_err_q.pop_front());
      end
    end
  end

  initial begin
    font_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    rst  = 1'b1;
    dig  = 4'hF;
    font = 8'hFF;
    repeat (3) @(negedge clk);
    check("reset_value", value, 0);
    check("reset_valid", valid, 0);
    check("reset_err", err, 0);
    check("reset_blank", blank, 0);
    rst = 1'b0;
    @(negedge clk);

    scan_value(1234, 0, 20);
    repeat (2) scan_value(0, 0, 14);
    repeat (2) scan_value(9999, 0, 14);

    // Glitches at slot entry and under a held anode
    scan_value(1357, 2, 14);
    for (int k = 0; k < 4; k++) begin
      logic [3:0] an;
      an = 4'hF; an[k] = 1'b0;
      model_capture(k, font_of(2468, k));
      hold(an, font_of(2468, k), 12);
      hold(an, 8'h80, 2);
      hold(an, font_of(2468, k), 6);
      gap(1);
    end

    for (int k = 0; k < 4; k++)
      dwell(k, (k == 1) ? 8'hFF : font_of(5678, k), 0, 8'h80, 20);
    scan_value(5678, 0, 20);
    check("blank_while_scanning", blank, 0);

    dwell(0, font_of(9876, 0), 0, 8'h80, 14);
    dwell(1, font_of(9876, 1), 0, 8'h80, 14);
    hold(4'hF, 8'hFF, BLANK + 5);
    model_clear();
    check("blank_set", blank, 1);
    model_capture(0, font_of(42, 0));
    hold(4'b1110, font_of(42, 0), 3);
    check("blank_cleared", blank, 0);
    hold(4'b1110, font_of(42, 0), 15);
    gap(1);
    for (int k = 1; k < 4; k++) dwell(k, font_of(42, k), 0, 8'h80, 16);

    dwell(0, font_of(8765, 0), 0, 8'h80, 14);
    dwell(1, font_of(8765, 1), 0, 8'h80, 14);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("midframe_reset_value", value, 0);
    check("midframe_reset_valid", valid, 0);
    rst = 1'b0;
    model_clear();
    m_last = 0;
    for (int i = 0; i < 4; i++) m_digit[i] = 0;
    @(negedge clk);
    scan_value(3210, 0, 16);

    repeat (40) random_frame();

    for (int i = 0; i < 100 && (exp_val_q.size() != 0 || exp_err_q.size() != 0); i++)
      @(negedge clk);
    check("pending_values", exp_val_q.size(), 0);
    check("pending_errs", exp_err_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
